// File: rtl/riscv_core_pkg.sv
// Shared core package: RV32M multiply op encodings and multiplier defaults.
package riscv_core_pkg;

  // funct3 encodings of the RV32M multiply group
  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011
  } mult_op_e;

  localparam int DEFAULT_MULT_LATENCY = 2;
  localparam int DEFAULT_MULT_TIMEOUT = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or above ptr, with wrap.
// Purely combinational so the owner can register the pointer itself.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  // Scan NUM_REQ slots starting at ptr; the first hit wins.
  always_comb begin
    int               j;
    logic [ID_W-1:0]  jj;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j  = (int'(ptr) + i) % NUM_REQ;
      jj = ID_W'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one pipelined RV32M multiplier between NUM_REQ requesters.
// One op in flight at a time: the multiplier re-latches operands on start.
module mult_arbiter
  import riscv_core_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int LATENCY        = DEFAULT_MULT_LATENCY,
  parameter int TIMEOUT_CYCLES = DEFAULT_MULT_TIMEOUT,
  parameter int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ-1:0][2:0] req_op_i,
  input  logic [NUM_REQ-1:0][31:0] req_a_i,
  input  logic [NUM_REQ-1:0][31:0] req_b_i,
  input  logic [NUM_REQ-1:0]      flush_i,
  output logic [NUM_REQ-1:0]      rsp_valid_o,
  input  logic [NUM_REQ-1:0]      rsp_ready_i,
  output logic [31:0]             rsp_data_o,
  output logic                    rsp_err_o,
  output logic                    mult_start_o,
  output logic [2:0]              mult_op_o,
  output logic [31:0]             mult_a_o,
  output logic [31:0]             mult_b_o,
  input  logic [31:0]             mult_result_i,
  input  logic                    mult_done_i,
  output logic                    busy_o
);

  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam bit CFG_OK = (TIMEOUT_CYCLES > LATENCY);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e             state_q;
  logic [ID_W-1:0]    rr_q, owner_q, grant_idx;
  logic               killed_q, err_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        rsp_data_q;
  logic [NUM_REQ-1:0] grant_oh;
  logic               grant_any, fire, owner_flush, timeout, drop;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req (req_valid_i),
    .ptr (rr_q),
    .gnt (grant_oh),
    .idx (grant_idx),
    .any (grant_any)
  );

  // Gate with rst_ni so nothing leaks out while reset is held.
  assign fire         = rst_ni && (state_q == IDLE) && grant_any;
  assign req_ready_o  = fire ? grant_oh : '0;
  assign mult_start_o = fire;
  assign mult_op_o    = fire ? req_op_i[grant_idx] : '0;
  assign mult_a_o     = fire ? req_a_i[grant_idx]  : '0;
  assign mult_b_o     = fire ? req_b_i[grant_idx]  : '0;

  assign owner_flush  = flush_i[owner_q];
  assign timeout      = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign drop         = killed_q || owner_flush;

  assign rsp_valid_o  = (state_q == RESP) ? (NUM_REQ'(1) << owner_q) : '0;
  assign rsp_data_o   = (state_q == RESP) ? rsp_data_q : '0;
  assign rsp_err_o    = (state_q == RESP) ? err_q : 1'b0;
  assign busy_o       = (state_q != IDLE);

  // Control FSM: grant, wait for done/timeout (honouring flush), deliver.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      owner_q    <= '0;
      killed_q   <= 1'b0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (fire) begin
          owner_q  <= grant_idx;
          rr_q     <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          cnt_q    <= '0;
          killed_q <= 1'b0;
          state_q  <= BUSY;
        end
        BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          if (mult_done_i) begin
            // flush in the done cycle wins: result is dropped
            rsp_data_q <= mult_result_i;
            err_q      <= 1'b0;
            state_q    <= drop ? IDLE : RESP;
          end else if (timeout) begin
            rsp_data_q <= '0;
            err_q      <= 1'b1;
            state_q    <= drop ? IDLE : RESP;
          end else if (owner_flush) begin
            // multiplier keeps running; we just discard its answer
            killed_q <= 1'b1;
          end
        end
        RESP: if (rsp_ready_i[owner_q] || owner_flush) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  a_cfg_ok:        assert property (@(posedge clk_i) CFG_OK);
  a_ready_onehot:  assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(req_ready_o));
  a_rsp_onehot:    assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(rsp_valid_o));
  a_start_in_idle: assert property (@(posedge clk_i) disable iff (!rst_ni) mult_start_o |-> state_q == IDLE);
  a_op_legal:      assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    mult_start_o |-> mult_op_o inside {MUL, MULH, MULHSU, MULHU});

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
Shares one pipelined RV32M multiplier (mult_unit) between NUM_REQ requesters, for example two issue ports or a hart plus a debug/test port. It arbitrates requests round-robin and drives the multiplier start/operand interface. It tracks the single in-flight operation, returns the result to its owner over a valid/ready handshake, supports per-requester flush, and raises an error response if the multiplier fails to signal done in time. Only one operation is in flight, because mult_unit re-latches its operands on every start.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
LATENCY, DEFAULT_MULT_LATENCY, mult_unit latency in cycles; forwarded to the instance parameter by the integrator
TIMEOUT_CYCLES, 16, maximum cycles in BUSY before error; must be > LATENCY
ID_W, $clog2(NUM_REQ) (min 1), requester index width

Ports:
clk_i  in  1  clock; single clock domain
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  per-requester request accept
req_op_i  in  NUM_REQ*3  per-requester funct3 (MUL=000, MULH=001, MULHSU=010, MULHU=011)
req_a_i  in  NUM_REQ*32  per-requester operand A
req_b_i  in  NUM_REQ*32  per-requester operand B
flush_i  in  NUM_REQ  per-requester kill of an accepted op
rsp_valid_o  out  NUM_REQ  result valid, one-hot to the owner
rsp_ready_i  in  NUM_REQ  owner accepts result
rsp_data_o  out  32  result word (shared by all requesters)
rsp_err_o  out  1  timeout error qualifier for rsp_data_o
mult_start_o  out  1  start pulse to mult_unit
mult_op_o  out  3  op_type to mult_unit
mult_a_o  out  32  operand A to mult_unit
mult_b_o  out  32  operand B to mult_unit
mult_result_i  in  32  mult_unit result_o
mult_done_i  in  1  mult_unit done_o
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async): state=IDLE, rr_q=0, owner_q=0, killed_q=0, cnt_q=0, rsp_data_q=0, err_q=0. All outputs are 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE: grant = first asserted req_valid_i searching from rr_q upward with wrap. req_ready_o[grant]=1 combinationally; all other ready bits 0. Ready is 0 in BUSY/RESP.
- On handshake (valid & ready):
  - mult_start_o=1 in the same cycle, with mult_op_o/a/b muxed combinationally from the grant.
  - owner_q<=grant, rr_q<=(grant+1) mod NUM_REQ, cnt_q<=0, killed_q<=0, go to BUSY.
- mult_start_o is 0 in all other cycles. Operand outputs are 0 when not starting.
- BUSY: cnt_q increments each cycle.
  - mult_done_i: rsp_data_q<=mult_result_i, err_q<=0. Go to IDLE if killed_q or flush_i[owner_q], else go to RESP.
  - cnt_q==TIMEOUT_CYCLES-1 without done: rsp_data_q<=0, err_q<=1. Go to RESP, or to IDLE if killed.
  - flush_i[owner_q] with no done: killed_q<=1, stay in BUSY until done or timeout. The multiplier is not aborted.
- RESP: rsp_valid_o[owner_q]=1, rsp_data_o=rsp_data_q, rsp_err_o=err_q.
  - rsp_ready_i[owner_q] or flush_i[owner_q]: go to IDLE.
  - Data is held stable while valid and not ready.
- rsp_data_o and rsp_err_o are 0 outside RESP.
- Timing:
  - Handshake at cycle T gives mult_done at T+LATENCY.
  - rsp_valid_o rises at T+LATENCY+1.
  - The next grant is possible the cycle after the response handshake.
  - Peak throughput is one op per LATENCY+2 cycles.
- Simultaneous events:
  - Done and flush in the same BUSY cycle: the flush wins and the result is dropped.
  - Flush on a non-owner requester: no effect.
  - mult_done_i in IDLE/RESP is spurious and ignored.
- Arithmetic is performed only by mult_unit. This block does no width conversion; results pass through as 32 bits.
- Assertions:
  - req_ready_o is one-hot0.
  - rsp_valid_o is one-hot0.
  - mult_start_o only in IDLE.
  - Request op in the legal set.

Decomposition:
- Shared riscv_core_pkg gets:
  - mult_op_e enum {MUL, MULH, MULHSU, MULHU} with the funct3 encodings.
  - DEFAULT_MULT_TIMEOUT constant.
- The FSM state enum stays local to the module.
- Sub-module rr_arbiter (NUM_REQ; req, pointer -> one-hot grant plus index), reusable for a future div_unit arbiter.

Test Plan:
- LATENCY=2. Requester 0: MUL 7*6. Response 0x0000002A on rsp_valid_o[0] 3 cycles after the handshake; rsp_err_o=0.
- Req0 and req1 both valid from reset: req0 MULH 0x80000000*0x80000000, req1 MULHU 0xFFFFFFFF*0xFFFFFFFF. Req0 is granted first and gets 0x40000000; req1 is granted next and gets 0xFFFFFFFE. Ready never overlaps.
- Req1 MULHSU 0xFFFFFFFF*0x00000002, with rsp_ready_i low for 5 cycles. rsp_data_o holds 0xFFFFFFFF stable; the FSM returns to IDLE on the ready cycle.
- Accept req0, then assert flush_i[0] in BUSY. mult_done is absorbed, rsp_valid_o stays 0, and req1 is granted the cycle after done.
- Tie mult_done_i=0 with TIMEOUT_CYCLES=16. rsp_valid_o[owner]=1 with rsp_err_o=1 and rsp_data_o=0, 17 cycles after the handshake.
- Assert rst_ni low mid-BUSY. All outputs go to 0 immediately; after release the first grant goes to requester 0.
